// File: rtl/sweep_pkg.sv
// Shared types and defaults for the instance sweep scheduler.
package sweep_pkg;

    localparam int unsigned N_INST_DEF  = 15;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned TMR_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/instance_sweep_scheduler_if.sv
// Sweep request / child enable bus between a controller and the scheduler.
interface instance_sweep_scheduler_if
    import sweep_pkg::*;
#(
    parameter int unsigned N_INST = N_INST_DEF
);
    logic              start_i;
    logic [N_INST-1:0] mask_i;
    logic [N_INST-1:0] inst_ack_i;
    logic [N_INST-1:0] inst_en_o;
    logic [IDX_W-1:0]  cur_idx_o;
    logic              busy_o;
    logic              done_o;
    logic [N_INST-1:0] fail_vec_o;

    modport master (
        output start_i, mask_i, inst_ack_i,
        input  inst_en_o, cur_idx_o, busy_o, done_o, fail_vec_o
    );

    modport slave (
        input  start_i, mask_i, inst_ack_i,
        output inst_en_o, cur_idx_o, busy_o, done_o, fail_vec_o
    );
endinterface

// File: rtl/instance_sweep_scheduler_lsb_pick.sv
// Lowest-set-bit picker: index of the lowest asserted bit plus a valid flag.
module lsb_pick
    import sweep_pkg::*;
#(
    parameter int unsigned N = N_INST_DEF
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = |vec;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/instance_sweep_scheduler.sv
// Visits masked child instances in ascending order, one at a time, with a
// per-child acknowledge timeout; all outputs come straight from flops.
module instance_sweep_scheduler
    import sweep_pkg::*;
#(
    parameter int unsigned N_INST  = N_INST_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instance_sweep_scheduler_if.slave  bus
);

    state_e            state_q, state_d;
    logic [N_INST-1:0] pend_q, pend_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [N_INST-1:0] fail_q, fail_d;
    logic [N_INST-1:0] en_q, en_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;

    lsb_pick #(.N(N_INST)) u_pick (
        .vec   (pend_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            idx_q   <= '0;
            tmr_q   <= '0;
            fail_q  <= '0;
            en_q    <= '0;
            cur_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            fail_q  <= fail_d;
            en_q    <= en_d;
            cur_q   <= cur_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; output flops are loaded from the next state so they
    // line up with the state they describe.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        fail_d  = fail_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    pend_d  = bus.mask_i;
                    fail_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!pick_valid) begin
                    state_d = DONE;
                end else begin
                    idx_d   = pick_idx;
                    tmr_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.inst_ack_i[idx_q]) begin
                    pend_d[idx_q] = 1'b0;
                    state_d       = SCAN;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    fail_d[idx_q] = 1'b1;
                    pend_d[idx_q] = 1'b0;
                    state_d       = SCAN;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        en_d   = (state_d == WAIT) ? ({{(N_INST-1){1'b0}}, 1'b1} << idx_d) : '0;
        cur_d  = (state_d == WAIT) ? idx_d : '0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign bus.inst_en_o  = en_q;
    assign bus.cur_idx_o  = cur_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.fail_vec_o = fail_q;

endmodule

// File: tb/tb_instance_sweep_scheduler.sv
// Directed bench for instance_sweep_scheduler: ordering, latency, timeout,
// ignored starts/acks and asynchronous reset abort.
module tb_instance_sweep_scheduler;
    import sweep_pkg::*;

    localparam int unsigned N  = 15;
    localparam int unsigned TO = 255;
    localparam int NEVER = 100000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    instance_sweep_scheduler_if #(.N_INST(N)) bus ();

    instance_sweep_scheduler #(.N_INST(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Ack policy: acknowledge the selected child once it has been enabled
    // for more than `delay` cycles; optionally spray acks on every other bit.
    function automatic logic [N-1:0] ack_for(input logic [N-1:0] en, input int hold,
                                             input int delay, input bit spurious);
        logic [N-1:0] a;
        a = '0;
        if (en != '0 && hold > delay) a = en;
        if (spurious) a = a | ~en;
        return a;
    endfunction

    // Runs one sweep from a start pulse and compares it with a small model.
    task automatic run_sweep(input string name, input logic [N-1:0] mask, input int delay,
                             input bit spurious, input int extra_cyc, input logic [N-1:0] extra_mask);
        logic [N-1:0] exp_en   [16];
        int           exp_st   [16];
        logic [N-1:0] obs_en   [16];
        int           obs_st   [16];
        int           obs_dur  [16];
        logic [N-1:0] fexp, prev_en, en;
        int dur, scan, nv, nobs, done_exp, ndone, dcyc, hold, bad, ci;

        // Model: SCAN costs one cycle, each visit costs min(delay+1, TO).
        dur  = (delay + 1 > int'(TO)) ? int'(TO) : delay + 1;
        scan = 1; nv = 0; fexp = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (mask[i]) begin
                exp_en[nv] = N'(1) << i;
                exp_st[nv] = scan + 1;
                scan       = scan + 1 + dur;
                if (delay + 1 > int'(TO)) fexp[i] = 1'b1;
                nv++;
            end
        end
        done_exp = scan + 1;

        nobs = 0; ndone = 0; dcyc = -1; hold = 0; bad = 0; prev_en = '0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.mask_i  = mask;
        for (int c = 1; c <= done_exp + 3; c++) begin
            @(negedge clk);
            bus.start_i = (c == extra_cyc);
            bus.mask_i  = (c == extra_cyc) ? extra_mask : ~mask;
            en = bus.inst_en_o;
            if (bus.done_o) begin ndone++; dcyc = c; end
            if (c == 1 && bus.busy_o !== 1'b1) bad++;
            ci = 0;
            for (int i = 0; i < int'(N); i++) if (en[i]) ci = i;
            if (!$onehot0(en) || bus.cur_idx_o !== IDX_W'(ci)) bad++;
            if (en != '0 && en == prev_en) begin
                hold++;
                if (nobs > 0) obs_dur[nobs-1]++;
            end else if (en != '0) begin
                hold = 1;
                if (nobs < 16) begin
                    obs_en[nobs] = en; obs_st[nobs] = c; obs_dur[nobs] = 1;
                end
                nobs++;
            end else begin
                hold = 0;
            end
            prev_en = en;
            bus.inst_ack_i = ack_for(en, hold, delay, spurious);
        end
        bus.inst_ack_i = '0;
        bus.start_i    = 1'b0;

        check({name, " done_count"}, ndone, 1);
        check({name, " done_cycle"}, dcyc, done_exp);
        check({name, " visits"}, nobs, nv);
        for (int k = 0; k < nv && k < nobs; k++) begin
            check($sformatf("%s v%0d en", name, k), obs_en[k], exp_en[k]);
            check($sformatf("%s v%0d start", name, k), obs_st[k], exp_st[k]);
            check($sformatf("%s v%0d dur", name, k), obs_dur[k], dur);
        end
        check({name, " fail_vec"}, bus.fail_vec_o, fexp);
        check({name, " busy_end"}, bus.busy_o, 1'b0);
        check({name, " cycle_bad"}, bad, 0);
    endtask

    initial begin
        logic [N-1:0] en, prev_en;
        int hold, hit, ndone;

        bus.start_i    = 1'b0;
        bus.mask_i     = '0;
        bus.inst_ack_i = '0;

        repeat (2) @(negedge clk);
        check("rst en",   bus.inst_en_o, '0);
        check("rst cur",  bus.cur_idx_o, '0);
        check("rst busy", bus.busy_o, 1'b0);
        check("rst done", bus.done_o, 1'b0);
        check("rst fail", bus.fail_vec_o, '0);
        rst_n = 1'b1;

        run_sweep("empty",   15'h0000, 0,     1'b0, -1, '0);
        run_sweep("m0005",   15'h0005, 1,     1'b0, -1, '0);
        run_sweep("tmo14",   15'h4000, NEVER, 1'b0, -1, '0);
        repeat (4) @(negedge clk);
        check("fail_hold", bus.fail_vec_o, 15'h4000);
        run_sweep("ack_tmo", 15'h4000, 254,   1'b0, -1, '0);
        run_sweep("all",     15'h7FFF, 0,     1'b1, -1, '0);
        run_sweep("busy_st", 15'h0012, 2,     1'b0, 3, 15'h7FFF);
        run_sweep("done_st", 15'h0001, 0,     1'b0, 4, 15'h7FFF);

        // Reset during the visit to child 3, with a start re-pulsed while busy.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.mask_i  = 15'h001C;
        hold = 0; hit = 0; prev_en = '0;
        for (int c = 1; c <= 60 && hit == 0; c++) begin
            @(negedge clk);
            bus.start_i = (c == 3);
            bus.mask_i  = (c == 3) ? 15'h7FFF : '0;
            en = bus.inst_en_o;
            hold = (en != '0 && en == prev_en) ? hold + 1 : ((en != '0) ? 1 : 0);
            prev_en = en;
            bus.inst_ack_i = ack_for(en, hold, 5, 1'b0);
            if (en == 15'h0008 && hold == 2) begin
                rst_n = 1'b0;
                #1;
                hit = 1;
                check("arst en",   bus.inst_en_o, '0);
                check("arst cur",  bus.cur_idx_o, '0);
                check("arst busy", bus.busy_o, 1'b0);
                check("arst done", bus.done_o, 1'b0);
                check("arst fail", bus.fail_vec_o, '0);
            end
        end
        bus.start_i    = 1'b0;
        bus.inst_ack_i = '0;
        check("arst reached", hit, 1);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done_o) ndone++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) ndone++;
        end
        check("arst no_done", ndone, 0);
        run_sweep("post_rst", 15'h0002, 0, 1'b0, -1, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
